// File: rtl/weight_dispatch_pkg.sv
// weight_dispatch_pkg: shared width helpers, full-threshold margin and lane slicing for weight_dispatch_fifo
package weight_dispatch_pkg;
    localparam int FULL_MARGIN = 1;
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction
endpackage

// File: rtl/weight_dispatch_fifo_sync_fifo.sv
// sync_fifo: count-based per-lane FIFO, no fall-through
//   push/din write the tail (caller keeps push low while full), pop retires the head
//   when non-empty; empty/full/head report the current state
module sync_fifo
    import weight_dispatch_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  empty,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] head
);
    localparam int CNT_WIDTH = cnt_width(FIFO_DEPTH);
    localparam int PTR_WIDTH = ptr_width(FIFO_DEPTH);
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  rd_q, wr_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  do_pop;
    assign do_pop = pop & ~empty;
    assign empty  = cnt_q == '0;
    assign full   = cnt_q == CNT_WIDTH'(FIFO_DEPTH);
    assign head   = mem_q[rd_q];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CNT_WIDTH'(push) - CNT_WIDTH'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/weight_dispatch_fifo.sv
// weight_dispatch_fifo: turns arbiter grants into weight reads and fans the words into per-MAC FIFOs
//   in : clk, rst (async, active high), addr/fetch_en/wr_en grant, all_done, mem_rdata, mac_ready
//   out: full backpressure, mem_rd_en/mem_addr read port, mac_valid/mac_wdata lanes, drain_done
//   optional macro WEIGHT_DISPATCH_OVF_CHECK_EN adds sticky ovf_err for dropped overflow grants
module weight_dispatch_fifo
    import weight_dispatch_pkg::*;
#(
    parameter int NUM_MACS   = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic                           fetch_en,
    input  logic [NUM_MACS-1:0]            wr_en,
    input  logic                           all_done,
    output logic                           full,
    output logic                           mem_rd_en,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic [DATA_WIDTH-1:0]          mem_rdata,
    output logic [NUM_MACS-1:0]            mac_valid,
    input  logic [NUM_MACS-1:0]            mac_ready,
    output logic [NUM_MACS*DATA_WIDTH-1:0] mac_wdata,
    output logic                           drain_done
`ifdef WEIGHT_DISPATCH_OVF_CHECK_EN
    ,
    output logic                           ovf_err
`endif
);
    localparam int CNT_WIDTH = cnt_width(FIFO_DEPTH);
    logic                pend_vld_q, drain_done_q, drain_done_d;
    logic [NUM_MACS-1:0] pend_mask_q, hit, ovf, near_full, fifo_empty, fifo_full;
    // The read port is held quiet while reset is asserted so its reset value is observable.
    assign mem_rd_en    = ~rst & fetch_en & |wr_en;
    assign mem_addr     = rst ? '0 : addr;
    assign hit          = fetch_en ? wr_en : '0;
    assign full         = |near_full;
    assign mac_valid    = ~fifo_empty;
    assign drain_done_d = drain_done_q | (all_done & ~pend_vld_q & &fifo_empty);
    assign drain_done   = drain_done_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld_q   <= 1'b0;
            pend_mask_q  <= '0;
            drain_done_q <= 1'b0;
        end else begin
            pend_vld_q   <= mem_rd_en;
            pend_mask_q  <= hit & ~ovf;
            drain_done_q <= drain_done_d;
        end
    end
    for (genvar g = 0; g < NUM_MACS; g++) begin : g_lane
        logic [CNT_WIDTH-1:0]  resv_q, resv_d;
        logic [DATA_WIDTH-1:0] head;
        logic                  pop;
        // resv counts stored plus in-flight words, so a lane at FIFO_DEPTH cannot take another grant.
        assign ovf[g]       = hit[g] & (resv_q == CNT_WIDTH'(FIFO_DEPTH));
        assign pop          = mac_valid[g] & mac_ready[g];
        assign resv_d       = resv_q + CNT_WIDTH'(hit[g] & ~ovf[g]) - CNT_WIDTH'(pop);
        assign near_full[g] = resv_q >= CNT_WIDTH'(FIFO_DEPTH - FULL_MARGIN);
        assign mac_wdata[lane_lsb(g, DATA_WIDTH) +: DATA_WIDTH] = fifo_empty[g] ? '0 : head;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) resv_q <= '0;
            else resv_q <= resv_d;
        end
        sync_fifo #(
            .DATA_WIDTH(DATA_WIDTH),
            .FIFO_DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk  (clk),
            .rst  (rst),
            .push (pend_vld_q & pend_mask_q[g] & ~fifo_full[g]),
            .pop  (pop),
            .din  (mem_rdata),
            .empty(fifo_empty[g]),
            .full (fifo_full[g]),
            .head (head)
        );
    end
`ifdef WEIGHT_DISPATCH_OVF_CHECK_EN
    logic ovf_err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_err_q <= 1'b0;
        else begin
            ovf_err_q <= ovf_err_q | (|ovf);
            assert (ovf == '0) else $error("weight_dispatch_fifo: overflow grant dropped, lanes %b", ovf);
        end
    end
    assign ovf_err = ovf_err_q;
`endif
endmodule

// File: tb/tb_weight_dispatch_fifo.sv
// tb_weight_dispatch_fifo: directed checks of reset, fill, backpressure, overflow, same-cycle push/pop and drain
module tb_weight_dispatch_fifo;
    logic        clk = 1'b0, rst = 1'b0, fetch_en = 1'b0, all_done = 1'b0;
    logic [7:0]  addr = '0;
    logic [3:0]  wr_en = '0, mac_ready = '0;
    logic [15:0] mem_rdata = '0;
    logic        full, mem_rd_en, drain_done;
    logic [7:0]  mem_addr;
    logic [3:0]  mac_valid;
    logic [63:0] mac_wdata;
`ifdef WEIGHT_DISPATCH_OVF_CHECK_EN
    logic        ovf_err;
`endif
    int n_chk = 0, n_bad = 0;
    bit mon_on = 1'b0;
    int exp_next [4];

    weight_dispatch_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .fetch_en  (fetch_en),
        .wr_en     (wr_en),
        .all_done  (all_done),
        .full      (full),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mac_valid (mac_valid),
        .mac_ready (mac_ready),
        .mac_wdata (mac_wdata),
        .drain_done(drain_done)
`ifdef WEIGHT_DISPATCH_OVF_CHECK_EN
        ,
        .ovf_err   (ovf_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) mem_rdata <= 16'h100 + 16'(mem_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lane(input int i);
        return mac_wdata[i*16 +: 16];
    endfunction

    task automatic grant(input logic [7:0] a, input logic [3:0] m);
        fetch_en = 1'b1;
        addr     = a;
        wr_en    = m;
        @(negedge clk);
    endtask

    task automatic idle();
        fetch_en = 1'b0;
        wr_en    = '0;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            for (int i = 0; i < 4; i++) begin
                if (mac_valid[i] && mac_ready[i]) begin
                    check("drain_word", 64'(lane(i)), 64'(exp_next[i] + 256));
                    exp_next[i] += 4;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_full", 64'(full), 0);
        check("rst_rd_en", 64'(mem_rd_en), 0);
        check("rst_mem_addr", 64'(mem_addr), 0);
        check("rst_valid", 64'(mac_valid), 0);
        check("rst_wdata", mac_wdata, 0);
        check("rst_drain", 64'(drain_done), 0);
        rst = 1'b0;
        @(negedge clk);
        grant(8'h55, 4'h1);
        fetch_en = 1'b0;
        wr_en    = '0;
        rst      = 1'b1;
        repeat (3) begin
            #1 check("mid_rst_rd_en", 64'(mem_rd_en), 0);
            check("mid_rst_addr", 64'(mem_addr), 0);
            check("mid_rst_valid", 64'(mac_valid), 0);
            @(negedge clk);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_no_push", 64'(mac_valid), 0);
        check("post_rst_full", 64'(full), 0);
        check("post_rst_drain", 64'(drain_done), 0);

        fetch_en = 1'b1;
        wr_en    = '0;
        addr     = 8'h09;
        #1 check("zero_mask_rd_en", 64'(mem_rd_en), 0);
        check("mem_addr_pass", 64'(mem_addr), 64'h09);
        @(negedge clk);
        fetch_en = 1'b1;
        wr_en    = 4'h1;
        addr     = 8'h00;
        #1 check("rd_en_on", 64'(mem_rd_en), 1);
        @(negedge clk);
        grant(8'h01, 4'h2);
        grant(8'h02, 4'h4);
        grant(8'h03, 4'h8);
        check("fill_latency", 64'(mac_valid), 64'h7);
        idle();
        check("fill_valid", 64'(mac_valid), 64'hF);
        check("fill_full", 64'(full), 0);
        for (int i = 0; i < 4; i++) check("fill_word", 64'(lane(i)), 64'(16'h100 + 16'(i)));
        check("zero_mask_no_push", 64'(mac_valid), 64'hF);
        mac_ready = 4'hF;
        @(negedge clk);
        mac_ready = 4'h0;
        check("fill_flushed", 64'(mac_valid), 0);

        check("bp_start_full", 64'(full), 0);
        grant(8'h10, 4'h1);
        grant(8'h11, 4'h1);
        check("bp_resv2_full", 64'(full), 0);
        grant(8'h12, 4'h1);
        check("bp_resv3_full", 64'(full), 1);
        grant(8'h13, 4'h1);
        idle();
        check("bp_lag_valid", 64'(mac_valid), 64'h1);
        check("bp_lag_full", 64'(full), 1);
`ifdef WEIGHT_DISPATCH_OVF_CHECK_EN
        check("bp_no_ovf", 64'(ovf_err), 0);
`endif

        grant(8'h20, 4'h1);
`ifdef WEIGHT_DISPATCH_OVF_CHECK_EN
        check("ovf_set", 64'(ovf_err), 1);
`endif
        idle();
        mac_ready = 4'h1;
        for (int k = 0; k < 4; k++) begin
            check("ovf_valid", 64'(mac_valid[0]), 1);
            check("ovf_order", 64'(lane(0)), 64'(16'h110 + 16'(k)));
            @(negedge clk);
        end
        check("ovf_dropped", 64'(mac_valid), 0);
        check("ovf_full_clear", 64'(full), 0);
`ifdef WEIGHT_DISPATCH_OVF_CHECK_EN
        check("ovf_sticky", 64'(ovf_err), 1);
`endif
        mac_ready = 4'h0;

        grant(8'h30, 4'h4);
        grant(8'h31, 4'h4);
        grant(8'h32, 4'h4);
        idle();
        check("sim_full_pre", 64'(full), 1);
        check("sim_valid_pre", 64'(mac_valid), 64'h4);
        mac_ready = 4'h4;
        check("sim_head0", 64'(lane(2)), 64'h130);
        grant(8'h33, 4'h4);
        check("sim_full_hold", 64'(full), 1);
        check("sim_head1", 64'(lane(2)), 64'h131);
        idle();
        check("sim_head2", 64'(lane(2)), 64'h132);
        check("sim_full_drop", 64'(full), 0);
        idle();
        check("sim_head3", 64'(lane(2)), 64'h133);
        idle();
        check("sim_empty", 64'(mac_valid), 0);
        mac_ready = 4'h0;

        exp_next  = '{0, 1, 2, 3};
        mac_ready = 4'hF;
        mon_on    = 1'b1;
        for (int a = 0, n = 0; a < 256 && n < 2000; n++) begin
            if (full) begin
                fetch_en = 1'b0;
                wr_en    = '0;
            end else begin
                fetch_en = 1'b1;
                addr     = 8'(a);
                wr_en    = 4'(1 << (a % 4));
                a++;
            end
            @(negedge clk);
        end
        fetch_en = 1'b0;
        wr_en    = '0;
        all_done = 1'b1;
        check("drain_early", 64'(drain_done), 0);
        for (int k = 0; k < 20 && mac_valid != 0; k++) @(negedge clk);
        check("drain_all_popped", 64'(mac_valid), 0);
        check("drain_not_yet", 64'(drain_done), 0);
        @(negedge clk);
        check("drain_done", 64'(drain_done), 1);
        for (int i = 0; i < 4; i++) check("drain_count", 64'(exp_next[i]), 64'(256 + i));
        mon_on   = 1'b0;
        all_done = 1'b0;
        @(negedge clk);
        check("drain_sticky", 64'(drain_done), 1);
        rst = 1'b1;
        #1 check("drain_rst", 64'(drain_done), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
